// File: rtl/hippo_mem_reader_if.sv
// Valid/ready byte stream carrying burst read data from the memory reader
// to its consumer. The reader drives through the master modport.
interface hippo_mem_reader_if #(
   parameter int DATA_W = 8
);
   logic              m_valid_o;
   logic              m_ready_i;
   logic [DATA_W-1:0] m_data_o;
   logic              m_last_o;

   modport master (
      output m_valid_o,
      output m_data_o,
      output m_last_o,
      input  m_ready_i
   );

   modport slave (
      input  m_valid_o,
      input  m_data_o,
      input  m_last_o,
      output m_ready_i
   );
endinterface

// File: rtl/hippo_mem_reader.sv
// Burst reader: walks a synchronous memory from a base address for a given
// beat count and streams the returned words out over a valid/ready channel.
// The memory returns data the cycle after mem_addr_o updates, so every read
// issued is captured one edge later into a 2-entry FIFO that feeds the stream.
module hippo_mem_reader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [ADDR_W-1:0]   base_addr_i,
   input  logic [ADDR_W:0]     len_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic                mem_we_o,
   input  logic [DATA_W-1:0]   mem_data_i,
   hippo_mem_reader_if.master  m
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     issue_left;
   logic [ADDR_W:0]     beats_left;
   logic                in_flight;
   logic [DATA_W-1:0]   fifo_mem [2];
   logic                wr_ptr;
   logic                rd_ptr;
   logic [1:0]          count;
   logic                done_q;

   logic                pop;
   logic                last_pop;
   logic                start_ok;
   logic                start_burst;
   logic                start_empty;
   logic                issue;
   logic [2:0]          occupancy;

   assign busy_o     = (state != IDLE);
   assign done_o     = done_q;
   assign mem_addr_o = addr_q;
   assign mem_we_o   = 1'b0;
   assign m.m_valid_o = (count != 2'd0);
   assign m.m_data_o  = fifo_mem[rd_ptr];
   assign m.m_last_o  = (count != 2'd0) && (beats_left == CNT_ONE);

   // Handshake decode and read-issue credit: a new read may only go out when
   // the FIFO is guaranteed a free slot for it on the following edge.
   always_comb begin
      pop         = (count != 2'd0) && m.m_ready_i;
      last_pop    = pop && (beats_left == CNT_ONE);
      start_ok    = (state == IDLE) && start_i && !abort_i;
      start_burst = start_ok && (len_i != '0);
      start_empty = start_ok && (len_i == '0);
      occupancy   = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
      issue       = (state == RUN) && !abort_i && (occupancy < 3'd2);
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_burst) begin
               state_next = (len_i == CNT_ONE) ? DRAIN : RUN;
            end
         end
         RUN: begin
            if (issue && (issue_left == CNT_ONE)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (last_pop) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (abort_i) begin
         state_next = IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Address generation, read tracking, FIFO storage and completion pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q      <= '0;
         issue_left  <= '0;
         beats_left  <= '0;
         in_flight   <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
         done_q      <= 1'b0;
      end else begin
         done_q <= !abort_i && (start_empty || ((state == DRAIN) && last_pop));
         if (abort_i) begin
            in_flight  <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            issue_left <= '0;
            beats_left <= '0;
         end else begin
            if (in_flight) begin
               fifo_mem[wr_ptr] <= mem_data_i;
               wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
               rd_ptr     <= ~rd_ptr;
               beats_left <= beats_left - CNT_ONE;
            end
            count <= count + {1'b0, in_flight} - {1'b0, pop};
            if (start_burst) begin
               addr_q     <= base_addr_i;
               in_flight  <= 1'b1;
               issue_left <= len_i - CNT_ONE;
               beats_left <= len_i;
            end else if (issue) begin
               addr_q     <= addr_q + ADDR_W'(1);
               in_flight  <= 1'b1;
               issue_left <= issue_left - CNT_ONE;
            end else begin
               in_flight  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hippo_mem_reader.sv
// Bench for hippo_mem_reader. Stimulus pushes the expected beats of every
// accepted burst into a scoreboard queue; an independent monitor pops and
// compares on each stream handshake and also checks done timing and
// stall stability. The memory has its address register in the DUT
// (mem_addr_o), so its read data is simply the word at that address.
module tb_hippo_mem_reader;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [9:0]  base = '0;
   logic [10:0] len = '0;
   logic        busy;
   logic        done;
   logic [9:0]  mem_addr;
   logic        mem_we;
   logic [7:0]  mem_data;
   logic [7:0]  mem [1024];

   beat_t       sb[$];
   int          checks = 0;
   int          failures = 0;
   int          hs_count = 0;
   logic        ready_rand = 1'b0;
   logic        we_seen = 1'b0;
   logic        done_due = 1'b0;
   logic        stall_prev = 1'b0;
   logic [7:0]  prev_data = '0;
   logic        prev_last = 1'b0;

   hippo_mem_reader_if #(.DATA_W(8)) stream ();

   hippo_mem_reader #(
      .ADDR_W(10),
      .DATA_W(8)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .abort_i    (abort),
      .base_addr_i(base),
      .len_i      (len),
      .busy_o     (busy),
      .done_o     (done),
      .mem_addr_o (mem_addr),
      .mem_we_o   (mem_we),
      .mem_data_i (mem_data),
      .m          (stream)
   );

   assign mem_data = mem[mem_addr];

   // Free-running clock.
   initial begin
      forever #5 clk = ~clk;
   end

   // Consumer ready: either always ready or a 50% coin toss each cycle.
   initial begin
      stream.m_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         stream.m_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Runaway guard.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives one start pulse and records the beats the burst must produce.
   // Returns #1 after the edge that sampled start.
   task automatic applyStimulus(input logic [9:0] b, input logic [10:0] l);
      beat_t e;
      @(posedge clk);
      #1;
      start = 1'b1;
      base  = b;
      len   = l;
      for (int n = 0; n < int'(l); n++) begin
         e.data = mem[(int'(b) + n) % 1024];
         e.last = (n == int'(l) - 1);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("burst_complete_in_budget", 32'(n < budget), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_valid"}, 32'(stream.m_valid_o), 32'd0);
      checkOutput({tag, "_last"}, 32'(stream.m_last_o), 32'd0);
      checkOutput({tag, "_data"}, 32'(stream.m_data_o), 32'd0);
      checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
      checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
   endtask

   // Monitor: scoreboard compare on handshakes, done timing, stall stability.
   initial begin
      beat_t e;
      logic  next_due;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            done_due   = 1'b0;
            stall_prev = 1'b0;
         end else begin
            if (mem_we) we_seen = 1'b1;
            checkOutput("done_timing", 32'(done), 32'(done_due));
            if (stall_prev) begin
               checkOutput("stall_valid_held", 32'(stream.m_valid_o), 32'd1);
               checkOutput("stall_data_stable", 32'(stream.m_data_o), 32'(prev_data));
               checkOutput("stall_last_stable", 32'(stream.m_last_o), 32'(prev_last));
            end
            next_due = 1'b0;
            if (stream.m_valid_o && stream.m_ready_i) begin
               hs_count++;
               checkOutput("beat_expected", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  checkOutput("beat_data", 32'(stream.m_data_o), 32'(e.data));
                  checkOutput("beat_last", 32'(stream.m_last_o), 32'(e.last));
                  next_due = e.last;
               end
            end
            if (start && len == 11'd0) next_due = 1'b1;
            if (abort) next_due = 1'b0;
            done_due   = next_due;
            stall_prev = stream.m_valid_o && !stream.m_ready_i && !abort;
            prev_data  = stream.m_data_o;
            prev_last  = stream.m_last_o;
         end
      end
   end

   // Main stimulus sequence.
   initial begin
      int snap;
      int n;
      logic [9:0] exp_addr [4];

      for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

      // Reset state
      #12;
      checkAllZero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic burst: latency 2, four consecutive beats, done after last
      ready_rand = 1'b0;
      applyStimulus(10'h010, 11'd4);
      @(negedge clk);
      checkOutput("lat_cycle1_valid", 32'(stream.m_valid_o), 32'd0);
      checkOutput("lat_cycle1_addr", 32'(mem_addr), 32'h010);
      checkOutput("lat_cycle1_busy", 32'(busy), 32'd1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("no_bubble_valid", 32'(stream.m_valid_o), 32'd1);
      end
      @(negedge clk);
      checkOutput("after_last_valid", 32'(stream.m_valid_o), 32'd0);
      checkOutput("done_after_last", 32'(done), 32'd1);
      waitIdle(50);

      // Address wrap at the top of memory
      exp_addr[0] = 10'h3FE;
      exp_addr[1] = 10'h3FF;
      exp_addr[2] = 10'h000;
      exp_addr[3] = 10'h001;
      applyStimulus(10'h3FE, 11'd4);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("wrap_addr_seq", 32'(mem_addr), 32'(exp_addr[c]));
      end
      waitIdle(50);

      // Empty burst
      applyStimulus(10'h123, 11'd0);
      @(negedge clk);
      checkOutput("empty_busy", 32'(busy), 32'd0);
      checkOutput("empty_done", 32'(done), 32'd1);
      checkOutput("empty_valid", 32'(stream.m_valid_o), 32'd0);
      @(negedge clk);
      checkOutput("empty_done_once", 32'(done), 32'd0);
      waitIdle(20);

      // Backpressure
      ready_rand = 1'b1;
      applyStimulus(10'($urandom), 11'd16);
      waitIdle(200);

      // Start while busy is ignored
      ready_rand = 1'b0;
      applyStimulus(10'h100, 11'd8);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      base  = 10'h200;
      len   = 11'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitIdle(100);
      checkOutput("ignored_start_busy", 32'(busy), 32'd0);

      // Abort at the third beat, then a fresh short burst
      snap = hs_count;
      applyStimulus(10'h050, 11'd10);
      n = 0;
      while (hs_count - snap < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("abort_reached_beat3", 32'(n < 200), 32'd1);
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      sb.delete();
      @(negedge clk);
      checkOutput("abort_valid_low", 32'(stream.m_valid_o), 32'd0);
      checkOutput("abort_busy_low", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      applyStimulus(10'h020, 11'd2);
      waitIdle(50);

      // Reset in the middle of a burst
      ready_rand = 1'b1;
      applyStimulus(10'h0C0, 11'd16);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("post_reset_no_beat", 32'(stream.m_valid_o), 32'd0);
      checkOutput("post_reset_idle", 32'(busy), 32'd0);

      // Randomised bursts over random memory contents
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 14; i++) begin
         logic [10:0] l;
         ready_rand = 1'($urandom_range(0, 1));
         case (i)
            3:       l = 11'd0;
            7:       l = 11'd1;
            10:      l = 11'd1024;
            default: l = 11'($urandom_range(1, 40));
         endcase
         applyStimulus(10'($urandom), l);
         waitIdle(4 * int'(l) + 50);
      end

      checkOutput("mem_we_never_high", 32'(we_seen), 32'd0);
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
